// File: rtl/mic_adc_capture_pkg.sv
// mic_adc_capture_pkg: shared audio-chain state encodings and default frame constants
package mic_adc_capture_pkg;
  typedef enum logic [1:0] {IDLE, SETUP, SHIFT, QUIET} adc_state_t;
  localparam int MIC_FRAME_BITS = 16;
  localparam int MIC_DATA_BITS = 12;
endpackage

// File: rtl/mic_adc_capture.sv
// mic_adc_capture: serial ADC frame capture with SCK divider, offset-binary to two's-complement sample
module mic_adc_capture
  import mic_adc_capture_pkg::*;
#(
  parameter int CKPCK = 2,
  parameter int FRAME_BITS = MIC_FRAME_BITS,
  parameter int DATA_BITS = MIC_DATA_BITS,
  parameter int QUIET_CYCLES = 8
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic                 i_en,
  input  logic                 i_start,
  output logic                 o_csn,
  output logic                 o_sck,
  input  logic                 i_miso,
  output logic                 o_valid,
  output logic [DATA_BITS-1:0] o_data,
  output logic                 o_err,
  output logic                 o_busy,
  output logic                 o_overrun
);
  localparam int HW = $clog2(CKPCK + 1);
  localparam int BW = $clog2(FRAME_BITS + 1);
  localparam int QW = $clog2(QUIET_CYCLES + 1);
  adc_state_t state, state_n;
  logic [HW-1:0] hcnt, hcnt_n;
  logic [BW-1:0] bcnt, bcnt_n;
  logic [QW-1:0] qcnt, qcnt_n;
  logic [FRAME_BITS-1:0] sr, sr_n;
  logic [DATA_BITS-1:0] data_n;
  logic csn_n, sck_n, valid_n, err_n, overrun_n, hlast, blast, qlast;
  assign hlast = hcnt == HW'(CKPCK - 1);
  assign blast = bcnt == BW'(FRAME_BITS - 1);
  assign qlast = qcnt == QW'(QUIET_CYCLES - 1);
  assign o_busy = state != IDLE;
  always_comb begin
    state_n = state;
    hcnt_n = hcnt;
    bcnt_n = bcnt;
    qcnt_n = qcnt;
    sr_n = sr;
    csn_n = 1'b1;
    sck_n = 1'b1;
    valid_n = 1'b0;
    data_n = o_data;
    err_n = o_err;
    overrun_n = i_start && state != IDLE;
    case (state)
      IDLE: begin
        hcnt_n = '0;
        bcnt_n = '0;
        qcnt_n = '0;
        state_n = i_start ? SETUP : IDLE;
        csn_n = !i_start;
      end
      SETUP: begin
        csn_n = 1'b0;
        hcnt_n = hlast ? '0 : hcnt + 1'b1;
        sck_n = !hlast;
        state_n = hlast ? SHIFT : SETUP;
      end
      SHIFT: begin
        csn_n = 1'b0;
        hcnt_n = hlast ? '0 : hcnt + 1'b1;
        sck_n = hlast ? !o_sck : o_sck;
        // Low half ends on the rising-edge-equivalent clock: capture MISO there
        if (hlast && !o_sck) sr_n = {sr[FRAME_BITS-2:0], i_miso};
        if (hlast && o_sck) begin
          bcnt_n = bcnt + 1'b1;
          if (blast) begin
            state_n = QUIET;
            bcnt_n = '0;
            csn_n = 1'b1;
            sck_n = 1'b1;
            valid_n = 1'b1;
            data_n = {!sr[DATA_BITS-1], sr[DATA_BITS-2:0]};
            err_n = |sr[FRAME_BITS-1:DATA_BITS];
          end
        end
      end
      default: begin
        qcnt_n = qlast ? '0 : qcnt + 1'b1;
        state_n = qlast ? IDLE : QUIET;
      end
    endcase
    if (!i_en) begin
      state_n = IDLE;
      hcnt_n = '0;
      bcnt_n = '0;
      qcnt_n = '0;
      csn_n = 1'b1;
      sck_n = 1'b1;
      valid_n = 1'b0;
      data_n = o_data;
      err_n = o_err;
    end
  end
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state <= IDLE;
      hcnt <= '0;
      bcnt <= '0;
      qcnt <= '0;
      sr <= '0;
      o_csn <= 1'b1;
      o_sck <= 1'b1;
      o_valid <= 1'b0;
      o_data <= '0;
      o_err <= 1'b0;
      o_overrun <= 1'b0;
    end else begin
      state <= state_n;
      hcnt <= hcnt_n;
      bcnt <= bcnt_n;
      qcnt <= qcnt_n;
      sr <= sr_n;
      o_csn <= csn_n;
      o_sck <= sck_n;
      o_valid <= valid_n;
      o_data <= data_n;
      o_err <= err_n;
      o_overrun <= overrun_n;
    end
  end
endmodule
